// File: rtl/pipe_pkg.sv
// Shared types and defaults for the elastic pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_FULL
  } pipe_occ_e;

  localparam int PIPE_CNT_W_DEF = 16;

  function automatic logic occ_has_beat(input pipe_occ_e occ);
    return occ != OCC_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; sticks at all-ones.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready, stall hold, flush-to-bubble and stall counter.
// Define PIPE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 203,
  parameter int CTRL_W     = 4,
  parameter bit CLEAR_DATA = 1'b0,
  parameter int CNT_W      = PIPE_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              accept;
  logic              transfer;
  logic              valid_q;
  logic              valid_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CTRL_W-1:0] ctrl_d;

  assign accept   = in_valid & in_ready;
  assign transfer = valid_q & out_ready;

`ifdef PIPE_SKID_EN

  pipe_occ_e         occ_q;
  pipe_occ_e         occ_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [DATA_W-1:0] skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [CTRL_W-1:0] skid_ctrl_d;
  logic              in_ready_q;
  logic              in_ready_d;

  assign in_ready = in_ready_q;

  always_comb begin
    occ_d       = occ_q;
    data_d      = data_q;
    ctrl_d      = ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      occ_d       = OCC_EMPTY;
      ctrl_d      = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA) begin
        data_d      = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            occ_d  = OCC_ONE;
            data_d = in_data;
            ctrl_d = in_ctrl;
          end
        end
        OCC_ONE: begin
          if (accept && !transfer) begin
            occ_d       = OCC_FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (accept && transfer) begin
            data_d = in_data;
            ctrl_d = in_ctrl;
          end else if (transfer) begin
            occ_d  = OCC_EMPTY;
            ctrl_d = '0;
          end
        end
        OCC_FULL: begin
          // The skid beat slides into main on the same edge the old main beat leaves.
          if (transfer) begin
            occ_d       = OCC_ONE;
            data_d      = skid_data_q;
            ctrl_d      = skid_ctrl_q;
            skid_ctrl_d = '0;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
    valid_d    = occ_has_beat(occ_d);
    in_ready_d = (occ_d != OCC_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q       <= OCC_EMPTY;
      in_ready_q  <= 1'b1;
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      skid_ctrl_q <= '0;
      if (CLEAR_DATA) begin
        data_q      <= '0;
        skid_data_q <= '0;
      end
    end else begin
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

`else

  assign in_ready = flush | ~valid_q | out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (CLEAR_DATA) begin
        data_d = '0;
      end
    end else if (accept) begin
      valid_d = 1'b1;
      data_d  = in_data;
      ctrl_d  = in_ctrl;
    end else if (transfer) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      if (CLEAR_DATA) begin
        data_q <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

`endif

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ctrl  = ctrl_q;

  // A flushed beat is discarded rather than stalled, so the flush cycle is not counted.
  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (valid_q & ~out_ready & ~flush),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench for pipe_stage_reg; a second instance uses CNT_W=3 for saturation.
module tb_pipe_stage_reg;

  localparam int DW = 203;
  localparam int CW = 4;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_ready;

  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [15:0]   stall_cnt;

  logic          in_ready3;
  logic          out_valid3;
  logic [DW-1:0] out_data3;
  logic [CW-1:0] out_ctrl3;
  logic [2:0]    stall_cnt3;

  beat_t exp_q[$];
  int    pass_count  = 0;
  int    check_count = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(
    .CNT_W(3)
  ) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready3),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid3),
    .out_ready(out_ready),
    .out_data (out_data3),
    .out_ctrl (out_ctrl3),
    .stall_cnt(stall_cnt3)
  );

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                               input logic ordy, input logic fl, input logic push);
    beat_t b;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    if (push) begin
      b.data = d;
      b.ctrl = c;
      exp_q.push_back(b);
    end
  endtask

  // Compare any beat leaving this cycle, then advance one edge.
  task automatic clockEdge();
    beat_t b;
    logic  drop;
    #1;
    drop = flush | ~rst_n;
    if (out_valid && out_ready) begin
      checkOutput("sb_pending", 256'(exp_q.size() != 0), 256'd1);
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        checkOutput("sb_data", 256'(out_data), 256'(b.data));
        checkOutput("sb_ctrl", 256'(out_ctrl), 256'(b.ctrl));
      end
    end
    @(posedge clk);
    #1;
    if (drop) exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    clockEdge();
    clockEdge();
    checkOutput("rst_valid", 256'(out_valid), 256'd0);
    checkOutput("rst_ctrl", 256'(out_ctrl), 256'd0);
    checkOutput("rst_stall", 256'(stall_cnt), 256'd0);

    // Reset while a beat with all-ones control is held.
    rst_n = 1'b1;
    applyStimulus(1'b1, DW'(32'h99), 4'hF, 1'b0, 1'b0, 1'b1);
    clockEdge();
    checkOutput("load_valid", 256'(out_valid), 256'd1);
    checkOutput("load_ctrl", 256'(out_ctrl), 256'hF);
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    clockEdge();
    checkOutput("rst2_valid", 256'(out_valid), 256'd0);
    checkOutput("rst2_ctrl", 256'(out_ctrl), 256'd0);
    checkOutput("rst2_stall", 256'(stall_cnt), 256'd0);
    checkOutput("rst2_data_hold", 256'(out_data), 256'h99);
    rst_n = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, DW'(i), CW'(i), 1'b1, 1'b0, 1'b1);
      #1;
      checkOutput("stream_ready", 256'(in_ready), 256'd1);
      if (i > 1) checkOutput("stream_valid", 256'(out_valid), 256'd1);
      clockEdge();
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    clockEdge();
    checkOutput("stream_idle_valid", 256'(out_valid), 256'd0);
    checkOutput("stream_idle_ctrl", 256'(out_ctrl), 256'd0);

    applyStimulus(1'b1, DW'(32'h55), 4'h3, 1'b0, 1'b0, 1'b1);
    clockEdge();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("hold_valid", 256'(out_valid), 256'd1);
      checkOutput("hold_data", 256'(out_data), 256'h55);
      checkOutput("hold_ctrl", 256'(out_ctrl), 256'h3);
      checkOutput("hold_ready", 256'(in_ready), 256'(SKID));
      clockEdge();
    end
    checkOutput("hold_stall", 256'(stall_cnt), 256'd5);
    checkOutput("hold_stall3", 256'(stall_cnt3), 256'd5);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    clockEdge();
    checkOutput("release_valid", 256'(out_valid), 256'd0);
    checkOutput("release_stall", 256'(stall_cnt), 256'd5);

    applyStimulus(1'b1, DW'(32'hA0), 4'hA, 1'b0, 1'b0, 1'b1);
    clockEdge();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    clockEdge();
    applyStimulus(1'b1, DW'(32'hBAD), 4'h7, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("flush_ready", 256'(in_ready), 256'd1);
    clockEdge();
    checkOutput("flush_valid", 256'(out_valid), 256'd0);
    checkOutput("flush_ctrl", 256'(out_ctrl), 256'd0);
    checkOutput("flush_stall", 256'(stall_cnt), 256'd6);
    checkOutput("flush_data_hold", 256'(out_data), 256'hA0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    clockEdge();
    checkOutput("post_flush_valid", 256'(out_valid), 256'd0);

    applyStimulus(1'b1, DW'(32'h77), 4'h5, 1'b0, 1'b0, 1'b1);
    clockEdge();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      clockEdge();
    end
    checkOutput("sat_stall3", 256'(stall_cnt3), 256'd7);
    checkOutput("sat_stall16", 256'(stall_cnt), 256'd16);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    clockEdge();
    checkOutput("sat_hold3", 256'(stall_cnt3), 256'd7);

`ifdef PIPE_SKID_EN
    applyStimulus(1'b1, DW'(32'hA1), 4'h1, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("skid_ready_empty", 256'(in_ready), 256'd1);
    clockEdge();
    applyStimulus(1'b1, DW'(32'hB2), 4'h2, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("skid_ready_one", 256'(in_ready), 256'd1);
    clockEdge();
    checkOutput("full_ready", 256'(in_ready), 256'd0);
    checkOutput("full_valid", 256'(out_valid), 256'd1);
    checkOutput("full_data", 256'(out_data), 256'hA1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    clockEdge();
    checkOutput("after_a_ready", 256'(in_ready), 256'd1);
    checkOutput("after_a_data", 256'(out_data), 256'hB2);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    clockEdge();
    checkOutput("skid_drain_valid", 256'(out_valid), 256'd0);
`endif

    checkOutput("sb_drained", 256'(exp_q.size()), 256'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
